// File: rtl/idu_pkg.sv
// Shared constants for the instruction-decode stage: format codes, RV32I/RV64I
// base opcodes, width defaults and the legal load-latency window.
package idu_pkg;

    localparam int XLEN_DEFAULT           = 32;
    localparam int XREG_ADDRWIDTH_DEFAULT = 5;
    localparam int LOAD_LATENCY_DEFAULT   = 1;
    localparam int LOAD_LATENCY_MIN       = 1;
    localparam int LOAD_LATENCY_MAX       = 3;

    localparam logic [31:0] ZERO_32BIT = 32'h0000_0000;

    typedef enum logic [2:0] {
        IT_U   = 3'd0,
        IT_J   = 3'd1,
        IT_I   = 3'd2,
        IT_S   = 3'd3,
        IT_R   = 3'd4,
        IT_B   = 3'd5,
        IT_ERR = 3'd7
    } it_type_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic bit load_latency_ok(input int lat);
        return (lat >= LOAD_LATENCY_MIN) && (lat <= LOAD_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/idu_decode.sv
// Pure combinational decode of one 32-bit instruction into register fields,
// enables, format code, sign-extended immediate and an illegal-opcode flag.
module idu_decode
    import idu_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int XREG_ADDRWIDTH = XREG_ADDRWIDTH_DEFAULT
) (
    input  logic [31:0]               instruction_i,
    output logic                      rs1_en_o,
    output logic                      rs2_en_o,
    output logic                      rd_en_o,
    output logic [XREG_ADDRWIDTH-1:0] dec_rs1_o,
    output logic [XREG_ADDRWIDTH-1:0] dec_rs2_o,
    output logic [XREG_ADDRWIDTH-1:0] dec_rd_o,
    output logic [6:0]                opcode_o,
    output logic [2:0]                func3_o,
    output logic [6:0]                func7_o,
    output logic [2:0]                it_type_o,
    output logic [XLEN-1:0]           imm_num_o,
    output logic                      illegal_o
);

    logic [31:0] inst;
    it_type_e    it_e;
    logic [31:0] imm32;

    assign inst = instruction_i;

    always_comb begin
        it_e = IT_ERR;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC:             it_e = IT_U;
            OPC_JAL:                        it_e = IT_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: it_e = IT_I;
            OPC_STORE:                      it_e = IT_S;
            OPC_OP:                         it_e = IT_R;
            OPC_BRANCH:                     it_e = IT_B;
            default:                        it_e = IT_ERR;
        endcase
    end

    // Every format is built to 32 bits first so a single sign extension covers XLEN=64.
    always_comb begin
        imm32 = ZERO_32BIT;
        case (it_e)
            IT_I:    imm32 = {{20{inst[31]}}, inst[31:20]};
            IT_S:    imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IT_B:    imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IT_U:    imm32 = {inst[31:12], 12'b0};
            IT_J:    imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = ZERO_32BIT;
        endcase
    end

    assign imm_num_o = XLEN'($signed(imm32));

    assign rs1_en_o  = (it_e == IT_B) || (it_e == IT_R) || (it_e == IT_S) || (it_e == IT_I);
    assign rs2_en_o  = (it_e == IT_S) || (it_e == IT_R) || (it_e == IT_B);
    assign rd_en_o   = ((it_e == IT_U) || (it_e == IT_R) || (it_e == IT_J) || (it_e == IT_I))
                       && (inst[11:7] != 5'd0);
    assign illegal_o = (it_e == IT_ERR);

    assign dec_rs1_o = XREG_ADDRWIDTH'(inst[19:15]);
    assign dec_rs2_o = XREG_ADDRWIDTH'(inst[24:20]);
    assign dec_rd_o  = XREG_ADDRWIDTH'(inst[11:7]);
    assign opcode_o  = inst[6:0];
    assign func3_o   = inst[14:12];
    assign func7_o   = inst[31:25];
    assign it_type_o = it_e;

endmodule

// File: rtl/idu_pipe.sv
// Registered decode stage between fetch and EX: output register, valid/ready
// handshake, load-use hazard detection with a configurable bubble count, flush.
module idu_pipe
    import idu_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int XREG_ADDRWIDTH = XREG_ADDRWIDTH_DEFAULT,
    parameter int LOAD_LATENCY   = LOAD_LATENCY_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      if_valid_i,
    output logic                      if_ready_o,
    input  logic [31:0]               instruction_i,
    input  logic [XLEN-1:0]           pc_in_i,
    input  logic                      ex_ready_i,
    output logic                      id_valid_o,
    output logic                      rs1_en_o,
    output logic                      rs2_en_o,
    output logic                      rd_en_o,
    output logic [XREG_ADDRWIDTH-1:0] dec_rs1_o,
    output logic [XREG_ADDRWIDTH-1:0] dec_rs2_o,
    output logic [XREG_ADDRWIDTH-1:0] dec_rd_o,
    output logic [6:0]                opcode_o,
    output logic [2:0]                func3_o,
    output logic [6:0]                func7_o,
    output logic [2:0]                it_type_o,
    output logic [XLEN-1:0]           imm_num_o,
    output logic                      illegal_o,
    output logic [XLEN-1:0]           pc_out_o,
    output logic [1:0]                load_cnt_o,
    output logic [XREG_ADDRWIDTH-1:0] load_rd_o
);

    if (!load_latency_ok(LOAD_LATENCY)) begin : g_bad_load_latency
        $error("idu_pipe: LOAD_LATENCY must lie in 1..3");
    end

    localparam logic [1:0] LOAD_CNT_INIT = 2'(LOAD_LATENCY - 1);

    typedef struct packed {
        logic                      rs1_en;
        logic                      rs2_en;
        logic                      rd_en;
        logic [XREG_ADDRWIDTH-1:0] rs1;
        logic [XREG_ADDRWIDTH-1:0] rs2;
        logic [XREG_ADDRWIDTH-1:0] rd;
        logic [6:0]                opcode;
        logic [2:0]                func3;
        logic [6:0]                func7;
        logic [2:0]                it_type;
        logic [XLEN-1:0]           imm;
        logic                      illegal;
        logic [XLEN-1:0]           pc;
    } id_fields_t;

    id_fields_t                fields_d, fields_q;
    logic                      id_valid_q;
    logic [XREG_ADDRWIDTH-1:0] load_rd_q;
    logic [1:0]                load_cnt_q;
    logic                      held_load, reg_haz, cnt_haz, if_ready, accept;

    idu_decode #(
        .XLEN           (XLEN),
        .XREG_ADDRWIDTH (XREG_ADDRWIDTH)
    ) u_decode (
        .instruction_i (instruction_i),
        .rs1_en_o      (fields_d.rs1_en),
        .rs2_en_o      (fields_d.rs2_en),
        .rd_en_o       (fields_d.rd_en),
        .dec_rs1_o     (fields_d.rs1),
        .dec_rs2_o     (fields_d.rs2),
        .dec_rd_o      (fields_d.rd),
        .opcode_o      (fields_d.opcode),
        .func3_o       (fields_d.func3),
        .func7_o       (fields_d.func7),
        .it_type_o     (fields_d.it_type),
        .imm_num_o     (fields_d.imm),
        .illegal_o     (fields_d.illegal)
    );
    assign fields_d.pc = pc_in_i;

    function automatic logic rs_hits(input id_fields_t f, input logic [XREG_ADDRWIDTH-1:0] tgt);
        return (f.rs1_en && (f.rs1 != '0) && (f.rs1 == tgt))
            || (f.rs2_en && (f.rs2 != '0) && (f.rs2 == tgt));
    endfunction

    assign held_load = id_valid_q && (fields_q.opcode == OPC_LOAD) && (fields_q.rd != '0);
    assign reg_haz   = held_load && rs_hits(fields_d, fields_q.rd);
    assign cnt_haz   = (load_cnt_q != 2'd0) && rs_hits(fields_d, load_rd_q);

    // Handshake: a transfer happens on a rising edge where if_valid_i and if_ready_o are
    // both high; if_ready_o never depends on if_valid_i. EX takes the output register on
    // any edge with ex_ready_i high, and id_valid_o low in that cycle is a bubble.
    assign if_ready = (!id_valid_q || ex_ready_i) && !reg_haz && !cnt_haz && !flush_i && !rst_i;
    assign accept   = if_valid_i && if_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_valid_q <= 1'b0;
            fields_q   <= '0;
            load_rd_q  <= '0;
            load_cnt_q <= 2'd0;
        end else begin
            if (flush_i) begin
                id_valid_q <= 1'b0;
            end else if (accept) begin
                id_valid_q <= 1'b1;
                fields_q   <= fields_d;
            end else if (ex_ready_i) begin
                id_valid_q <= 1'b0;
            end

            // Counter ticks only on ex_ready so a stalled EX never eats a required bubble.
            if (flush_i) begin
                load_cnt_q <= 2'd0;
            end else if (held_load && ex_ready_i) begin
                load_rd_q  <= fields_q.rd;
                load_cnt_q <= LOAD_CNT_INIT;
            end else if ((load_cnt_q != 2'd0) && ex_ready_i) begin
                load_cnt_q <= load_cnt_q - 2'd1;
            end
        end
    end

    assign if_ready_o = if_ready;
    assign id_valid_o = id_valid_q;
    assign rs1_en_o   = fields_q.rs1_en;
    assign rs2_en_o   = fields_q.rs2_en;
    assign rd_en_o    = fields_q.rd_en;
    assign dec_rs1_o  = fields_q.rs1;
    assign dec_rs2_o  = fields_q.rs2;
    assign dec_rd_o   = fields_q.rd;
    assign opcode_o   = fields_q.opcode;
    assign func3_o    = fields_q.func3;
    assign func7_o    = fields_q.func7;
    assign it_type_o  = fields_q.it_type;
    assign imm_num_o  = fields_q.imm;
    assign illegal_o  = fields_q.illegal;
    assign pc_out_o   = fields_q.pc;
    assign load_cnt_o = load_cnt_q;
    assign load_rd_o  = load_rd_q;

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: instance a (XLEN=32, LOAD_LATENCY=1) and instance b
// (XLEN=64, LOAD_LATENCY=3), each with its own expected queue and monitor.
module tb_idu_pipe;

    localparam logic [2:0] T_U = 3'd0, T_J = 3'd1, T_I = 3'd2, T_S = 3'd3;
    localparam logic [2:0] T_R = 3'd4, T_B = 3'd5, T_ERR = 3'd7;

    localparam logic [31:0] I_LUI   = 32'h123450B7;
    localparam logic [31:0] I_LUIN  = 32'h800000B7;
    localparam logic [31:0] I_BEQ   = 32'hFE000EE3;
    localparam logic [31:0] I_SW    = 32'hFE20AC23;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_NOP   = 32'h00000013;
    localparam logic [31:0] I_ADDI  = 32'hFFF00393;
    localparam logic [31:0] I_ILL   = 32'hFFFFFFFF;
    localparam logic [31:0] I_LW    = 32'h0000A283;
    localparam logic [31:0] I_ADD5  = 32'h00228333;
    localparam logic [31:0] I_ADD4  = 32'h00220333;

    // ---------------- clock / reset / stimulus signals ----------------
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush    [2];
    logic        if_valid [2];
    logic        ex_ready [2];
    logic [31:0] instr    [2];
    logic [63:0] pc       [2];

    logic        a_if_ready, a_id_valid, a_rs1_en, a_rs2_en, a_rd_en, a_ill;
    logic [4:0]  a_rs1, a_rs2, a_rd, a_lrd;
    logic [6:0]  a_opc, a_f7;
    logic [2:0]  a_f3, a_it;
    logic [31:0] a_imm, a_pc;
    logic [1:0]  a_cnt;

    logic        b_if_ready, b_id_valid, b_rs1_en, b_rs2_en, b_rd_en, b_ill;
    logic [4:0]  b_rs1, b_rs2, b_rd, b_lrd;
    logic [6:0]  b_opc, b_f7;
    logic [2:0]  b_f3, b_it;
    logic [63:0] b_imm, b_pc;
    logic [1:0]  b_cnt;

    idu_pipe #(.XLEN(32), .XREG_ADDRWIDTH(5), .LOAD_LATENCY(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[0]), .if_valid_i(if_valid[0]),
        .if_ready_o(a_if_ready), .instruction_i(instr[0]), .pc_in_i(pc[0][31:0]),
        .ex_ready_i(ex_ready[0]), .id_valid_o(a_id_valid), .rs1_en_o(a_rs1_en),
        .rs2_en_o(a_rs2_en), .rd_en_o(a_rd_en), .dec_rs1_o(a_rs1), .dec_rs2_o(a_rs2),
        .dec_rd_o(a_rd), .opcode_o(a_opc), .func3_o(a_f3), .func7_o(a_f7),
        .it_type_o(a_it), .imm_num_o(a_imm), .illegal_o(a_ill), .pc_out_o(a_pc),
        .load_cnt_o(a_cnt), .load_rd_o(a_lrd)
    );

    idu_pipe #(.XLEN(64), .XREG_ADDRWIDTH(5), .LOAD_LATENCY(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[1]), .if_valid_i(if_valid[1]),
        .if_ready_o(b_if_ready), .instruction_i(instr[1]), .pc_in_i(pc[1]),
        .ex_ready_i(ex_ready[1]), .id_valid_o(b_id_valid), .rs1_en_o(b_rs1_en),
        .rs2_en_o(b_rs2_en), .rd_en_o(b_rd_en), .dec_rs1_o(b_rs1), .dec_rs2_o(b_rs2),
        .dec_rd_o(b_rd), .opcode_o(b_opc), .func3_o(b_f3), .func7_o(b_f7),
        .it_type_o(b_it), .imm_num_o(b_imm), .illegal_o(b_ill), .pc_out_o(b_pc),
        .load_cnt_o(b_cnt), .load_rd_o(b_lrd)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [2:0]  en;      // {rs1_en, rs2_en, rd_en}
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [2:0]  it;
        logic        ill;
        logic [63:0] imm;
        logic [63:0] pc;
        int          gap;     // bubbles since previous transfer, -1 = not checked
    } exp_t;

    typedef struct packed {
        logic [2:0]  en;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [2:0]  it;
        logic        ill;
        logic [63:0] imm;
        logic [63:0] pc;
    } obs_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    obs_t obs_a, obs_b;
    exp_t ea, eb;
    int   n_vec = 0;
    int   n_bad = 0;
    int   gap_a = 0;
    int   gap_b = 0;

    always_comb begin
        obs_a = '{en: {a_rs1_en, a_rs2_en, a_rd_en}, rs1: a_rs1, rs2: a_rs2, rd: a_rd,
                  opc: a_opc, f3: a_f3, f7: a_f7, it: a_it, ill: a_ill,
                  imm: 64'(a_imm), pc: 64'(a_pc)};
        obs_b = '{en: {b_rs1_en, b_rs2_en, b_rd_en}, rs1: b_rs1, rs2: b_rs2, rd: b_rd,
                  opc: b_opc, f3: b_f3, f7: b_f7, it: b_it, ill: b_ill,
                  imm: b_imm, pc: b_pc};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic compare(input string tag, input obs_t o, input exp_t e, input int gap);
        string p;
        p = $sformatf("%s@pc=%0h", tag, e.pc);
        chk({p, ".pc"},      o.pc,        e.pc);
        chk({p, ".imm"},     o.imm,       e.imm);
        chk({p, ".enables"}, 64'(o.en),   64'(e.en));
        chk({p, ".rs1"},     64'(o.rs1),  64'(e.rs1));
        chk({p, ".rs2"},     64'(o.rs2),  64'(e.rs2));
        chk({p, ".rd"},      64'(o.rd),   64'(e.rd));
        chk({p, ".opcode"},  64'(o.opc),  64'(e.opc));
        chk({p, ".func3"},   64'(o.f3),   64'(e.f3));
        chk({p, ".func7"},   64'(o.f7),   64'(e.f7));
        chk({p, ".it_type"}, 64'(o.it),   64'(e.it));
        chk({p, ".illegal"}, 64'(o.ill),  64'(e.ill));
        if (e.gap >= 0) chk({p, ".bubbles"}, 64'(gap), 64'(e.gap));
    endtask

    // Monitor: a transfer to EX is id_valid with ex_ready; bubbles are !id_valid with ex_ready.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_id_valid === 1'b1 && ex_ready[0]) begin
                if (exp_a.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL a.unexpected_output: got pc 0x%0h, expected none", a_pc);
                end else begin
                    ea = exp_a.pop_front();
                    compare("a", obs_a, ea, gap_a);
                end
                gap_a = 0;
            end else if (a_id_valid === 1'b0 && ex_ready[0]) begin
                gap_a++;
            end
            if (b_id_valid === 1'b1 && ex_ready[1]) begin
                if (exp_b.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL b.unexpected_output: got pc 0x%0h, expected none", b_pc);
                end else begin
                    eb = exp_b.pop_front();
                    compare("b", obs_b, eb, gap_b);
                end
                gap_b = 0;
            end else if (b_id_valid === 1'b0 && ex_ready[1]) begin
                gap_b++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic rdy(input int k);
        return (k == 0) ? a_if_ready : b_if_ready;
    endfunction

    function automatic exp_t mk(input logic [2:0] en, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [6:0] opc, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [2:0] it, input logic ill,
                                input logic [63:0] imm, input int gap);
        exp_t e;
        e = '{en: en, rs1: rs1, rs2: rs2, rd: rd, opc: opc, f3: f3, f7: f7, it: it,
              ill: ill, imm: imm, pc: 64'h0, gap: gap};
        return e;
    endfunction

    task automatic issue(input int k, input logic [31:0] ins, input logic [63:0] p);
        int budget;
        budget = 0;
        instr[k] = ins; pc[k] = p; if_valid[k] = 1'b1;
        do begin
            @(negedge clk);
            budget++;
        end while (rdy(k) !== 1'b1 && budget < 50);
        n_vec++;
        if (rdy(k) !== 1'b1) begin
            n_bad++;
            $display("FAIL issue_timeout dut=%0d pc=0x%0h: got no if_ready, expected acceptance", k, p);
        end
        @(posedge clk); #1;
        if_valid[k] = 1'b0;
    endtask

    task automatic send(input int k, input logic [31:0] ins, input logic [63:0] p, input exp_t e);
        exp_t x;
        x = e;
        x.pc = p;
        if (k == 0) exp_a.push_back(x); else exp_b.push_back(x);
        issue(k, ins, p);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            flush[k] = 1'b0; if_valid[k] = 1'b1; ex_ready[k] = 1'b1;
            instr[k] = I_LUI; pc[k] = 64'h0;
        end

        @(posedge clk);
        @(negedge clk);
        chk("reset.a.if_ready", 64'(a_if_ready), 64'h0);
        chk("reset.a.id_valid", 64'(a_id_valid), 64'h0);
        chk("reset.a.imm",      64'(a_imm),      64'h0);
        chk("reset.a.pc",       64'(a_pc),       64'h0);
        chk("reset.a.rd",       64'(a_rd),       64'h0);
        chk("reset.a.opcode",   64'(a_opc),      64'h0);
        chk("reset.a.load_cnt", 64'(a_cnt),      64'h0);
        chk("reset.b.if_ready", 64'(b_if_ready), 64'h0);
        chk("reset.b.id_valid", 64'(b_id_valid), 64'h0);
        chk("reset.b.imm",      b_imm,           64'h0);
        chk("reset.b.load_rd",  64'(b_lrd),      64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        if_valid[0] = 1'b0; if_valid[1] = 1'b0;
        idle(2);

        // Instance a: every format back to back.
        send(0, I_LUI,  64'h100, mk(3'b001, 5'd8,  5'd3,  5'd1,  7'h37, 3'd5, 7'h09, T_U,   1'b0, 64'h12345000, -1));
        send(0, I_BEQ,  64'h104, mk(3'b110, 5'd0,  5'd0,  5'd29, 7'h63, 3'd0, 7'h7F, T_B,   1'b0, 64'hFFFFFFFC, 0));
        send(0, I_SW,   64'h108, mk(3'b110, 5'd1,  5'd2,  5'd24, 7'h23, 3'd2, 7'h7F, T_S,   1'b0, 64'hFFFFFFF8, 0));
        send(0, I_JAL,  64'h10C, mk(3'b001, 5'd0,  5'd8,  5'd1,  7'h6F, 3'd0, 7'h00, T_J,   1'b0, 64'h00000008, 0));
        send(0, I_NOP,  64'h110, mk(3'b100, 5'd0,  5'd0,  5'd0,  7'h13, 3'd0, 7'h00, T_I,   1'b0, 64'h00000000, 0));
        send(0, I_ADDI, 64'h114, mk(3'b101, 5'd0,  5'd31, 5'd7,  7'h13, 3'd0, 7'h7F, T_I,   1'b0, 64'hFFFFFFFF, 0));
        send(0, I_ILL,  64'h118, mk(3'b000, 5'd31, 5'd31, 5'd31, 7'h7F, 3'd7, 7'h7F, T_ERR, 1'b1, 64'h0, 0));
        idle(3);

        // Instance a: load-use with one bubble, then an independent consumer with none.
        send(0, I_LW,   64'h200, mk(3'b101, 5'd1, 5'd0, 5'd5, 7'h03, 3'd2, 7'h00, T_I, 1'b0, 64'h0, -1));
        send(0, I_ADD5, 64'h204, mk(3'b111, 5'd5, 5'd2, 5'd6, 7'h33, 3'd0, 7'h00, T_R, 1'b0, 64'h0, 1));
        idle(3);
        send(0, I_LW,   64'h300, mk(3'b101, 5'd1, 5'd0, 5'd5, 7'h03, 3'd2, 7'h00, T_I, 1'b0, 64'h0, -1));
        send(0, I_ADD4, 64'h304, mk(3'b111, 5'd4, 5'd2, 5'd6, 7'h33, 3'd0, 7'h00, T_R, 1'b0, 64'h0, 0));

        // Back-pressure while ADD is held; the next SW goes in on the release cycle.
        ex_ready[0] = 1'b0;
        exp_a.push_back(mk(3'b110, 5'd1, 5'd2, 5'd24, 7'h23, 3'd2, 7'h7F, T_S, 1'b0, 64'hFFFFFFF8, 0));
        exp_a[$].pc = 64'h308;
        instr[0] = I_SW; pc[0] = 64'h308; if_valid[0] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("stall.if_ready", 64'(a_if_ready), 64'h0);
            chk("stall.id_valid", 64'(a_id_valid), 64'h1);
            chk("stall.pc",       64'(a_pc),       64'h304);
            chk("stall.rd",       64'(a_rd),       64'h6);
            chk("stall.opcode",   64'(a_opc),      64'h33);
        end
        @(posedge clk); #1;
        ex_ready[0] = 1'b1;
        @(negedge clk);
        chk("release.if_ready", 64'(a_if_ready), 64'h1);
        @(posedge clk); #1;
        if_valid[0] = 1'b0;
        idle(3);

        // Flush beats a simultaneous offer: nothing is accepted.
        flush[0] = 1'b1; instr[0] = I_ADDI; pc[0] = 64'h400; if_valid[0] = 1'b1;
        @(negedge clk);
        chk("flush.if_ready", 64'(a_if_ready), 64'h0);
        @(posedge clk); #1;
        flush[0] = 1'b0; if_valid[0] = 1'b0;
        chk("flush.id_valid", 64'(a_id_valid), 64'h0);
        idle(2);

        // Instance b: 64-bit sign extension.
        send(1, I_BEQ,  64'h1000, mk(3'b110, 5'd0, 5'd0, 5'd29, 7'h63, 3'd0, 7'h7F, T_B, 1'b0, 64'hFFFFFFFFFFFFFFFC, -1));
        send(1, I_LUIN, 64'h1004, mk(3'b001, 5'd0, 5'd0, 5'd1,  7'h37, 3'd0, 7'h40, T_U, 1'b0, 64'hFFFFFFFF80000000, 0));
        idle(4);

        // Instance b: three bubbles for a direct consumer.
        send(1, I_LW,   64'h1100, mk(3'b101, 5'd1, 5'd0, 5'd5, 7'h03, 3'd2, 7'h00, T_I, 1'b0, 64'h0, -1));
        send(1, I_ADD5, 64'h1104, mk(3'b111, 5'd5, 5'd2, 5'd6, 7'h33, 3'd0, 7'h00, T_R, 1'b0, 64'h0, 3));
        idle(5);

        // Instance b: an independent op slips in while the counter runs; the consumer waits the rest.
        send(1, I_LW,   64'h1200, mk(3'b101, 5'd1, 5'd0, 5'd5, 7'h03, 3'd2, 7'h00, T_I, 1'b0, 64'h0, -1));
        send(1, I_ADD4, 64'h1204, mk(3'b111, 5'd4, 5'd2, 5'd6, 7'h33, 3'd0, 7'h00, T_R, 1'b0, 64'h0, 0));
        send(1, I_ADD5, 64'h1208, mk(3'b111, 5'd5, 5'd2, 5'd6, 7'h33, 3'd0, 7'h00, T_R, 1'b0, 64'h0, 2));
        idle(5);

        // Instance b: flush in the middle of the load-use stall cancels the remaining bubble.
        send(1, I_LW, 64'h1300, mk(3'b101, 5'd1, 5'd0, 5'd5, 7'h03, 3'd2, 7'h00, T_I, 1'b0, 64'h0, -1));
        fork
            send(1, I_ADD5, 64'h1304, mk(3'b111, 5'd5, 5'd2, 5'd6, 7'h33, 3'd0, 7'h00, T_R, 1'b0, 64'h0, 2));
            begin
                @(posedge clk); #1;
                flush[1] = 1'b1;
                @(negedge clk);
                chk("bflush.if_ready", 64'(b_if_ready), 64'h0);
                @(posedge clk); #1;
                flush[1] = 1'b0;
                chk("bflush.id_valid", 64'(b_id_valid), 64'h0);
                chk("bflush.load_cnt", 64'(b_cnt),      64'h0);
            end
        join
        idle(2);

        for (int i = 0; i < 50 && (exp_a.size() != 0 || exp_b.size() != 0); i++) @(negedge clk);
        chk("drain.a", 64'(exp_a.size()), 64'h0);
        chk("drain.b", 64'(exp_b.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_vec++; n_bad++;
        $display("FAIL watchdog: got no end of sequence, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
